// File: rtl/sad_pkg.sv
// Shared sizing helpers and default geometry for the SAD pipeline engine.
package sad_pkg;

    localparam int SAD_PIX_W      = 8;
    localparam int SAD_LANES      = 4;
    localparam int SAD_BLK_PIXELS = 16;
    localparam int SAD_IDX_W      = 16;

    // Ceiling log2; returns 0 for an input of 1.
    function automatic int sad_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Accumulator width: a full window of maximum differences fits without overflow.
    function automatic int sad_acc_w(input int pix_w, input int blk_pixels);
        return pix_w + sad_clog2(blk_pixels);
    endfunction

    // Adder-tree output width: one beat's worth of maximum differences.
    function automatic int sad_tree_w(input int pix_w, input int lanes);
        return pix_w + sad_clog2(lanes);
    endfunction

endpackage

// File: rtl/sad_adder_tree.sv
// Registered lane reduction for the SAD pipeline (second stage).
// Sums LANES unsigned differences and passes the beat's valid/first/last tags alongside.
module sad_adder_tree import sad_pkg::*; #(
    parameter int LANES = SAD_LANES,
    parameter int IN_W  = SAD_PIX_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_en,
    input  logic                                 i_clear,
    input  logic                                 i_valid,
    input  logic                                 i_first,
    input  logic                                 i_last,
    input  logic [LANES*IN_W-1:0]                i_diff,
    output logic                                 o_valid,
    output logic                                 o_first,
    output logic                                 o_last,
    output logic [sad_tree_w(IN_W, LANES)-1:0]   o_sum
);

    localparam int OUT_W = sad_tree_w(IN_W, LANES);

    logic [OUT_W-1:0] w_sum;
    logic [OUT_W-1:0] r_sum;
    logic             r_valid;
    logic             r_first;
    logic             r_last;

    // Combinational sum of all lane differences, widened so it cannot wrap.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + OUT_W'(i_diff[i*IN_W +: IN_W]);
        end
    end

    // Stage register: clear flushes, enable low holds during a downstream stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_sum   <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_sum   <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_first <= i_first;
            r_last  <= i_last;
            r_sum   <= w_sum;
        end
    end

    assign o_valid = r_valid;
    assign o_first = r_first;
    assign o_last  = r_last;
    assign o_sum   = r_sum;

endmodule

// File: rtl/sad_pipe_engine.sv
// Pipelined sum-of-absolute-differences engine: S1 abs diff, S2 adder tree, S3 accumulate.
// One window SAD per BLK_PIXELS pixels, delivered with a valid/ready handshake and window index.
// Optional minimum tracking (best_sad/best_idx) is built only when MIN_TRACK_EN is defined.
module sad_pipe_engine import sad_pkg::*; #(
    parameter int PIX_W      = SAD_PIX_W,
    parameter int LANES      = SAD_LANES,
    parameter int BLK_PIXELS = SAD_BLK_PIXELS,
    parameter int IDX_W      = SAD_IDX_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clear,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [LANES*PIX_W-1:0]                  cur_pix,
    input  logic [LANES*PIX_W-1:0]                  ref_pix,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [sad_acc_w(PIX_W, BLK_PIXELS)-1:0] sad_result,
    output logic [IDX_W-1:0]                        win_idx,
    output logic [sad_acc_w(PIX_W, BLK_PIXELS)-1:0] best_sad,
    output logic [IDX_W-1:0]                        best_idx
);

    localparam int ACC_W  = sad_acc_w(PIX_W, BLK_PIXELS);
    localparam int SUM_W  = sad_tree_w(PIX_W, LANES);
    localparam int BEATS  = BLK_PIXELS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? sad_clog2(BEATS) : 1;

    logic                     w_stall;
    logic                     w_accept;
    logic                     w_first;
    logic                     w_last;
    logic [LANES*PIX_W-1:0]   w_diff;
    logic [BEAT_W-1:0]        r_beat;

    logic                     r_s1_valid;
    logic                     r_s1_first;
    logic                     r_s1_last;
    logic [LANES*PIX_W-1:0]   r_s1_diff;

    logic                     w_s2_valid;
    logic                     w_s2_first;
    logic                     w_s2_last;
    logic [SUM_W-1:0]         w_s2_sum;

    logic [ACC_W-1:0]         w_total;
    logic [ACC_W-1:0]         r_acc;
    logic [ACC_W-1:0]         r_sad;
    logic                     r_out_valid;
    logic [IDX_W-1:0]         r_win_cnt;
    logic [IDX_W-1:0]         r_win_idx;

    // An unaccepted result freezes the whole pipeline; clear always wins over a beat.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && !w_stall && !clear;
    assign w_first  = (r_beat == '0);
    assign w_last   = (r_beat == BEAT_W'(BEATS - 1));

    // Per-lane unsigned absolute difference.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PIX_W-1:0] w_cur;
            logic [PIX_W-1:0] w_ref;
            assign w_cur = cur_pix[gi*PIX_W +: PIX_W];
            assign w_ref = ref_pix[gi*PIX_W +: PIX_W];
            assign w_diff[gi*PIX_W +: PIX_W] = (w_cur >= w_ref) ? (w_cur - w_ref) : (w_ref - w_cur);
        end
    endgenerate

    // Beat position within the current window, advanced only by accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (clear) begin
            r_beat <= '0;
        end else if (w_accept) begin
            r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
        end
    end

    // S1: register lane differences with their window-position tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_diff  <= '0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_diff  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            r_s1_diff  <= w_diff;
        end
    end

    // S2: registered reduction of the lane differences.
    sad_adder_tree #(
        .LANES (LANES),
        .IN_W  (PIX_W)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_en    (!w_stall),
        .i_clear (clear),
        .i_valid (r_s1_valid),
        .i_first (r_s1_first),
        .i_last  (r_s1_last),
        .i_diff  (r_s1_diff),
        .o_valid (w_s2_valid),
        .o_first (w_s2_first),
        .o_last  (w_s2_last),
        .o_sum   (w_s2_sum)
    );

    // Running window total including the beat currently leaving S2.
    assign w_total = w_s2_first ? ACC_W'(w_s2_sum) : (r_acc + ACC_W'(w_s2_sum));

    // S3: accumulate beats and publish the window total on the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_sad       <= '0;
            r_out_valid <= 1'b0;
            r_win_cnt   <= '0;
            r_win_idx   <= '0;
        end else if (clear) begin
            r_acc       <= '0;
            r_sad       <= '0;
            r_out_valid <= 1'b0;
            r_win_cnt   <= '0;
            r_win_idx   <= '0;
        end else if (!w_stall) begin
            // Not stalled means any held result was just taken, so valid follows the new arrival.
            r_out_valid <= w_s2_valid && w_s2_last;
            if (w_s2_valid) begin
                r_acc <= w_total;
                if (w_s2_last) begin
                    r_sad     <= w_total;
                    r_win_idx <= r_win_cnt;
                    r_win_cnt <= r_win_cnt + IDX_W'(1);
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign sad_result = r_sad;
    assign win_idx    = r_win_idx;

`ifdef MIN_TRACK_EN
    logic [ACC_W-1:0] r_best_sad;
    logic [IDX_W-1:0] r_best_idx;

    // Keep the strictly smallest window total; ties leave the earlier window in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_sad <= '1;
            r_best_idx <= '0;
        end else if (clear) begin
            r_best_sad <= '1;
            r_best_idx <= '0;
        end else if (!w_stall && w_s2_valid && w_s2_last && (w_total < r_best_sad)) begin
            r_best_sad <= w_total;
            r_best_idx <= r_win_cnt;
        end
    end

    assign best_sad = r_best_sad;
    assign best_idx = r_best_idx;
`else
    assign best_sad = '0;
    assign best_idx = '0;
`endif

endmodule

// File: tb/tb_sad_pipe_engine.sv
// Scoreboard bench for sad_pipe_engine: windows are issued by the main process,
// expected SADs are queued at issue time, and a monitor checks each delivered result.
`timescale 1ns/1ps
module tb_sad_pipe_engine;

    localparam int PIX_W = 8;
    localparam int LANES = 4;
    localparam int BLK   = 16;
    localparam int IDX_W = 16;
    localparam int ACC_W = 12;
    localparam int BEATS = BLK / LANES;
`ifdef MIN_TRACK_EN
    localparam int BEST_INIT = 4095;
`else
    localparam int BEST_INIT = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] cur_pix;
    logic [LANES*PIX_W-1:0] ref_pix;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [ACC_W-1:0]       sad_result;
    logic [IDX_W-1:0]       win_idx;
    logic [ACC_W-1:0]       best_sad;
    logic [IDX_W-1:0]       best_idx;

    typedef struct {
        int sad;
        int idx;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               checks = 0;
    int               errors = 0;
    int               model_idx;
    int               model_best_sad = BEST_INIT;
    int               model_best_idx = 0;
    int               stall_cycles = 0;
    logic [PIX_W-1:0] win_cur[BLK];
    logic [PIX_W-1:0] win_ref[BLK];
    bit               bp_random = 0;
    bit               arm_hold = 0;
    bit               hold_done = 0;
    int               hold_cnt = 0;
    bit               prev_stall = 0;
    bit               prev_clear = 0;
    logic [ACC_W-1:0] prev_sad = '0;
    logic [IDX_W-1:0] prev_idx = '0;

    sad_pipe_engine #(
        .PIX_W      (PIX_W),
        .LANES      (LANES),
        .BLK_PIXELS (BLK),
        .IDX_W      (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cur_pix    (cur_pix),
        .ref_pix    (ref_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sad_result (sad_result),
        .win_idx    (win_idx),
        .best_sad   (best_sad),
        .best_idx   (best_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Consumer side: ready high, random, or held low for 5 cycles once a result appears.
    always @(posedge clk) begin
        #1;
        if (!arm_hold) hold_done = 0;
        if (arm_hold && !hold_done && out_valid) begin
            hold_cnt  = 5;
            hold_done = 1;
        end
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else if (bp_random) begin
            out_ready = ($urandom_range(0, 99) < 60);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: flow-control rules, result hold during stall, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall     = 0;
            model_best_sad = BEST_INIT;
            model_best_idx = 0;
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid && !out_ready) stall_cycles++;
            if (prev_stall && !prev_clear) begin
                check("hold_valid", out_valid, 1);
                check("hold_sad", sad_result, prev_sad);
                check("hold_idx", win_idx, prev_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0d expected=none", sad_result);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("RESULT win_idx=%0d sad=%0d expected_idx=%0d expected_sad=%0d",
                             win_idx, sad_result, mon_e.idx, mon_e.sad);
                    check("sad_result", sad_result, mon_e.sad);
                    check("win_idx", win_idx, mon_e.idx);
`ifdef MIN_TRACK_EN
                    if (mon_e.sad < model_best_sad) begin
                        model_best_sad = mon_e.sad;
                        model_best_idx = mon_e.idx;
                    end
`endif
                    check("best_sad", best_sad, model_best_sad);
                    check("best_idx", best_idx, model_best_idx);
                end
            end
            if (clear) begin
                model_best_sad = BEST_INIT;
                model_best_idx = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_clear = clear;
            prev_sad   = sad_result;
            prev_idx   = win_idx;
        end
    end

    // Present one beat (called just after a rising edge) until the engine takes it.
    task automatic send_beat(input logic [LANES*PIX_W-1:0] c, input logic [LANES*PIX_W-1:0] r);
        bit acc;
        bit ok;
        int guard;
        cur_pix  = c;
        ref_pix  = r;
        in_valid = 1'b1;
        ok       = 0;
        guard    = 0;
        while (!ok && guard < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            ok = acc;
            guard++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout actual=not_accepted expected=accepted");
        end
    endtask

    // Send the window held in win_cur/win_ref and queue its expected SAD.
    task automatic send_window();
        int total;
        logic [LANES*PIX_W-1:0] c;
        logic [LANES*PIX_W-1:0] r;
        total = 0;
        for (int p = 0; p < BLK; p++) begin
            if (win_cur[p] > win_ref[p]) total += int'(win_cur[p]) - int'(win_ref[p]);
            else                         total += int'(win_ref[p]) - int'(win_cur[p]);
        end
        for (int b = 0; b < BEATS; b++) begin
            if (bp_random && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                cur_pix  = $urandom;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            for (int l = 0; l < LANES; l++) begin
                c[l*PIX_W +: PIX_W] = win_cur[b*LANES + l];
                r[l*PIX_W +: PIX_W] = win_ref[b*LANES + l];
            end
            send_beat(c, r);
        end
        exp_q.push_back('{total, model_idx});
        model_idx = (model_idx + 1) % (1 << IDX_W);
    endtask

    task automatic fill_const(input int cv, input int rv);
        for (int p = 0; p < BLK; p++) begin
            win_cur[p] = PIX_W'(cv);
            win_ref[p] = PIX_W'(rv);
        end
    endtask

    // Spread a target SAD over the window with random base values and sign.
    task automatic fill_total(input int total);
        int d;
        int base;
        for (int p = 0; p < BLK; p++) begin
            d    = total / BLK + ((p < total % BLK) ? 1 : 0);
            base = $urandom_range(0, 255 - d);
            if ($urandom_range(0, 1) == 1) begin
                win_cur[p] = PIX_W'(base + d);
                win_ref[p] = PIX_W'(base);
            end else begin
                win_cur[p] = PIX_W'(base);
                win_ref[p] = PIX_W'(base + d);
            end
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < BLK; p++) begin
            win_cur[p] = PIX_W'($urandom);
            win_ref[p] = PIX_W'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b1;
        cur_pix  = $urandom;
        ref_pix  = $urandom;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        model_idx = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_before;
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        cur_pix  = '0;
        ref_pix  = '0;
        model_idx = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sad", sad_result, 0);
        check("rst_win_idx", win_idx, 0);
        check("rst_best_sad", best_sad, BEST_INIT);
        check("rst_best_idx", best_idx, 0);
        @(posedge clk);
        #1;

        // Single window, diff 1 everywhere, with latency check
        fill_const(5, 4);
        send_window();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", out_valid, 0);
        @(negedge clk);
        check("lat_cycle3", out_valid, 1);
        @(posedge clk);
        #1;
        drain();

        // Maximum difference in both directions
        fill_const(255, 0);
        send_window();
        fill_const(0, 255);
        send_window();
        in_valid = 1'b0;
        drain();

        // Clear mid-window drops the partial sum and restarts the window index
        send_beat({LANES{8'h11}}, {LANES{8'h10}});
        send_beat({LANES{8'h11}}, {LANES{8'h10}});
        do_clear();
        @(negedge clk);
        check("clr_out_valid", out_valid, 0);
        check("clr_win_idx", win_idx, 0);
        check("clr_best_sad", best_sad, BEST_INIT);
        check("clr_best_idx", best_idx, 0);
        @(posedge clk);
        #1;
        fill_const(12, 10);
        send_window();
        in_valid = 1'b0;
        drain();

        // Backpressure: three back-to-back windows, consumer stalls 5 cycles on first result
        stall_before = stall_cycles;
        arm_hold = 1;
        fill_const(5, 4);
        send_window();
        fill_const(255, 0);
        send_window();
        fill_total(0);
        send_window();
        in_valid = 1'b0;
        drain();
        arm_hold = 0;
        check("bp_stalled", (stall_cycles - stall_before) >= 5, 1);

        // Minimum tracking over 40, 12, 12, 30
        do_clear();
        fill_total(40); send_window();
        fill_total(12); send_window();
        fill_total(12); send_window();
        fill_total(30); send_window();
        in_valid = 1'b0;
        drain();
`ifdef MIN_TRACK_EN
        check("min_best_sad", best_sad, 12);
        check("min_best_idx", best_idx, 1);
`else
        check("min_best_sad", best_sad, 0);
        check("min_best_idx", best_idx, 0);
`endif

        // Randomized windows with input gaps and random consumer backpressure
        bp_random = 1;
        for (int w = 0; w < 24; w++) begin
            if ($urandom_range(0, 2) == 0) fill_total($urandom_range(0, 4080));
            else                           fill_random();
            send_window();
        end
        in_valid  = 1'b0;
        bp_random = 0;
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
